// File: rtl/fir_frame_collector_if.sv
// fir_frame_collector_if: FIR sample stream in, parallel frame handshake out
interface fir_frame_collector_if #(parameter int N_PTS = 16, parameter int DW = 16);
   logic                fir_valid;
   logic [DW-1:0]       fir_d;
   logic                frame_ack;
   logic                frame_valid;
   logic [N_PTS*DW-1:0] frame_data;
   logic                overflow;
   modport master (output fir_valid, fir_d, frame_ack, input frame_valid, frame_data, overflow);
   modport slave (input fir_valid, fir_d, frame_ack, output frame_valid, frame_data, overflow);
endinterface

// File: rtl/fir_frame_collector.sv
// fir_frame_collector: ping-pong collector of FIR samples into N_PTS-sample parallel frames
module fir_frame_collector #(parameter int N_PTS = 16, parameter int DW = 16) (
   input logic clk,
   input logic rst,
   fir_frame_collector_if.slave bus
);
   localparam int AW = $clog2(N_PTS);
   typedef enum logic {FILL, HOLD} state_t;
   state_t state, state_n;
   logic sel;
   logic [AW-1:0] wr_idx;
   logic [DW-1:0] mem [2][N_PTS];
   logic accept, last, swap, fv, ov;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= FILL;
         sel <= 1'b0;
         wr_idx <= '0;
         fv <= 1'b0;
         ov <= 1'b0;
         for (int b = 0; b < 2; b++)
            for (int k = 0; k < N_PTS; k++)
               mem[b][k] <= '0;
      end else begin
         state <= state_n;
         sel <= sel ^ swap;
         fv <= swap | (fv & ~bus.frame_ack);
         ov <= ov | (state == HOLD && bus.fir_valid);
         if (accept) begin
            mem[sel][wr_idx] <= bus.fir_d;
            wr_idx <= wr_idx + AW'(1);
         end
      end
   end
   always_comb begin
      state_n = state == FILL ? ((last && !swap) ? HOLD : FILL) : (bus.frame_ack ? FILL : HOLD);
   end
   // sel is the bank being filled; the other bank is presented
   always_comb begin
      accept = state == FILL && bus.fir_valid;
      last = accept && wr_idx == AW'(N_PTS - 1);
      swap = (last && (!fv || bus.frame_ack)) || (state == HOLD && bus.frame_ack);
      bus.frame_valid = fv;
      bus.overflow = ov;
      bus.frame_data = '0;
      for (int k = 0; k < N_PTS; k++)
         bus.frame_data[k*DW +: DW] = mem[~sel][k];
   end
endmodule

// File: tb/tb_fir_frame_collector.sv
// tb_fir_frame_collector: directed checks of frame collection, handshake, overflow and reset
module tb_fir_frame_collector;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int errors = 0;
   int checks = 0;
   fir_frame_collector_if #(.N_PTS(16), .DW(16)) bus ();
   fir_frame_collector #(.N_PTS(16), .DW(16)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   function automatic logic [255:0] frame(input int s);
      logic [255:0] f;
      for (int k = 0; k < 16; k++) f[k*16 +: 16] = 16'(s + k);
      return f;
   endfunction

   task automatic chk_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_frame(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic v, input logic [15:0] d, input logic a);
      bus.fir_valid = v;
      bus.fir_d = d;
      bus.frame_ack = a;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int s, input int n, input logic ack_first);
      for (int i = 0; i < n; i++) step(1'b1, 16'(s + i), ack_first && i == 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(1'b0, 16'h0, 1'b0);
      rst = 1'b0;
   endtask

   initial begin
      bus.fir_valid = 1'b0;
      bus.fir_d = '0;
      bus.frame_ack = 1'b0;
      step(1'b0, 16'h0, 1'b0);
      step(1'b0, 16'h0, 1'b0);
      chk_bit("t1_fv", bus.frame_valid, 1'b0);
      chk_bit("t1_ov", bus.overflow, 1'b0);
      chk_frame("t1_data", bus.frame_data, '0);
      rst = 1'b0;
      // T2 single frame, held without ack
      send(1, 15, 1'b0);
      chk_bit("t2_fv_early", bus.frame_valid, 1'b0);
      send(16, 1, 1'b0);
      chk_bit("t2_fv", bus.frame_valid, 1'b1);
      chk_frame("t2_data", bus.frame_data, frame(1));
      chk_bit("t2_first", bus.frame_data[15:0] == 16'h0001, 1'b1);
      chk_bit("t2_last", bus.frame_data[255:240] == 16'h0010, 1'b1);
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 16'h0, 1'b0);
         chk_frame("t2_stable", bus.frame_data, frame(1));
         chk_bit("t2_fv_stable", bus.frame_valid, 1'b1);
      end
      step(1'b0, 16'h0, 1'b1);
      chk_bit("t2_fv_acked", bus.frame_valid, 1'b0);
      step(1'b0, 16'h0, 1'b1);
      chk_bit("t2_ack_ignored", bus.frame_valid, 1'b0);
      // T3 streaming with prompt ack
      do_reset();
      send(1, 16, 1'b0);
      chk_frame("t3_f1", bus.frame_data, frame(1));
      send(17, 1, 1'b1);
      chk_bit("t3_fv_cleared", bus.frame_valid, 1'b0);
      send(18, 15, 1'b0);
      chk_bit("t3_fv", bus.frame_valid, 1'b1);
      chk_frame("t3_f2", bus.frame_data, frame(17));
      chk_bit("t3_ov", bus.overflow, 1'b0);
      // T4 overflow while holding
      do_reset();
      send(1, 16, 1'b0);
      send(17, 16, 1'b0);
      chk_bit("t4_ov_pre", bus.overflow, 1'b0);
      chk_frame("t4_held_pre", bus.frame_data, frame(1));
      send(33, 8, 1'b0);
      chk_bit("t4_ov", bus.overflow, 1'b1);
      chk_frame("t4_held", bus.frame_data, frame(1));
      step(1'b1, 16'h0099, 1'b1);
      chk_bit("t4_fv_swap", bus.frame_valid, 1'b1);
      chk_frame("t4_f2", bus.frame_data, frame(17));
      chk_bit("t4_ov_sticky", bus.overflow, 1'b1);
      step(1'b0, 16'h0, 1'b1);
      chk_bit("t4_fv_acked", bus.frame_valid, 1'b0);
      send(41, 16, 1'b0);
      chk_frame("t4_after_drop", bus.frame_data, frame(41));
      chk_bit("t4_ov_still", bus.overflow, 1'b1);
      // T1 asynchronous reset mid-run
      rst = 1'b1;
      #1;
      chk_bit("t1_async_fv", bus.frame_valid, 1'b0);
      chk_bit("t1_async_ov", bus.overflow, 1'b0);
      chk_frame("t1_async_data", bus.frame_data, '0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      // T5 gaps pause collection
      send(1, 7, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 16'hdead, 1'b0);
      chk_bit("t5_fv_gap", bus.frame_valid, 1'b0);
      send(8, 9, 1'b0);
      chk_bit("t5_fv", bus.frame_valid, 1'b1);
      chk_frame("t5_data", bus.frame_data, frame(1));
      // T6 ack coinciding with next frame completion
      send(17, 15, 1'b0);
      chk_frame("t6_old", bus.frame_data, frame(1));
      step(1'b1, 16'd32, 1'b1);
      chk_bit("t6_fv", bus.frame_valid, 1'b1);
      chk_frame("t6_new", bus.frame_data, frame(17));
      chk_bit("t6_ov", bus.overflow, 1'b0);
      // T7 reset discards partial frame
      send(256, 10, 1'b0);
      do_reset();
      chk_bit("t7_fv_reset", bus.frame_valid, 1'b0);
      send(1, 15, 1'b0);
      chk_bit("t7_fv_early", bus.frame_valid, 1'b0);
      send(16, 1, 1'b0);
      chk_bit("t7_fv", bus.frame_valid, 1'b1);
      chk_frame("t7_data", bus.frame_data, frame(1));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
